// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2**ADDR_WIDTH x DATA_WIDTH register file with two registered
// read ports, one write port and a sweep FSM that zeroes every register.
// Optional build macro REG_FILE_BYPASS_EN: when defined, an accepted write
// is forwarded to any read port addressing the same register on that edge.
// Without it, a read-during-write returns the pre-write contents.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] write_select,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] read_select_a,
    input  logic [ADDR_WIDTH-1:0] read_select_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  sweep_req,
    output logic                  sweep_busy,
    output logic                  sweep_done
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rd_a_q, rd_a_d;
    logic [DATA_WIDTH-1:0]   rd_b_q, rd_b_d;
    logic                    wr_accept;

    // Writes are only taken outside SWEEP so the sweep owns the array.
    assign write_ready = (state_q != SWEEP);
    assign wr_accept   = write_enable && write_ready;
    assign read_data_a = rd_a_q;
    assign read_data_b = rd_b_q;

    // Sweep FSM next state, index and status outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                sweep_busy = 1'b1;
                // Index wraps naturally at the register width.
                idx_d      = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-port next values, with optional write-to-read forwarding.
    always_comb begin
        rd_a_d = regs_q[read_select_a];
        rd_b_d = regs_q[read_select_b];
`ifdef REG_FILE_BYPASS_EN
        // Only an accepted write forwards; a dropped one never appears.
        if (wr_accept && (write_select == read_select_a)) begin
            rd_a_d = write_data;
        end
        if (wr_accept && (write_select == read_select_b)) begin
            rd_b_d = write_data;
        end
`endif
    end

    // FSM state, sweep index and registered read data.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    // Register array: host writes, or one zeroed entry per SWEEP cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_accept) begin
            regs_q[write_select] <= write_data;
        end else if (state_q == SWEEP) begin
            regs_q[idx_q] <= '0;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: default 8x16 instance plus a
// 32-bit x 8 instance. Expectations follow the build macro
// REG_FILE_BYPASS_EN when the bench is compiled with it.
module tb_reg_file_2r1w;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        clear;

    // Default-size instance signals
    logic [3:0]  ws, ra, rb;
    logic        we, wr, sreq, sbusy, sdone;
    logic [7:0]  wd, rda, rdb;

    // Wide instance signals
    logic [2:0]  w_ws, w_ra, w_rb;
    logic        w_we, w_wr, w_sreq, w_sbusy, w_sdone;
    logic [31:0] w_wd, w_rda, w_rdb;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_2r1w dut (
        .clock(clk), .clear(clear),
        .write_select(ws), .write_enable(we), .write_data(wd), .write_ready(wr),
        .read_select_a(ra), .read_select_b(rb),
        .read_data_a(rda), .read_data_b(rdb),
        .sweep_req(sreq), .sweep_busy(sbusy), .sweep_done(sdone)
    );

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut_w (
        .clock(clk), .clear(clear),
        .write_select(w_ws), .write_enable(w_we), .write_data(w_wd), .write_ready(w_wr),
        .read_select_a(w_ra), .read_select_b(w_rb),
        .read_data_a(w_rda), .read_data_b(w_rdb),
        .sweep_req(w_sreq), .sweep_busy(w_sbusy), .sweep_done(w_sdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] ws;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        clear = 1'b1;
        ws = '0; we = 1'b0; wd = '0; ra = '0; rb = '0; sreq = 1'b0;
        w_ws = '0; w_we = 1'b0; w_wd = '0; w_ra = '0; w_rb = '0; w_sreq = 1'b0;

        // Reset state
        #1 clear = 1'b0;
        tick(); tick();
        chk("reset_rda", rda, 0);
        chk("reset_rdb", rdb, 0);
        chk("reset_busy", sbusy, 0);
        chk("reset_done", sdone, 0);
        chk("reset_ready", wr, 1);
        chk("reset_wide_rda", w_rda, 0);
        clear = 1'b1;

        // Directed table: write/read with 1-cycle read latency
        vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd0,  4'd0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  4'd4, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 4'd5,  8'h11, 4'd3,  4'd3, 8'hA5, 8'hA5};
        vecs[3] = '{1'b1, 4'd5,  8'h22, 4'd5,  4'd3, (BYP ? 8'h22 : 8'h11), 8'hA5};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd5,  4'd5, 8'h22, 8'h22};
        vecs[5] = '{1'b1, 4'd15, 8'hFF, 4'd15, 4'd0, (BYP ? 8'hFF : 8'h00), 8'h00};
        vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd3, 8'hFF, 8'hA5};
        for (int i = 0; i < 7; i++) begin
            we = vecs[i].we; ws = vecs[i].ws; wd = vecs[i].wd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            tick();
            chk($sformatf("vec%0d_a", i), rda, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), rdb, vecs[i].eb);
        end
        we = 1'b0;

        // Fill r0..r15 with 0x10+i, then sweep
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; ws = 4'(i); wd = 8'(8'h10 + i);
            tick();
        end
        we = 1'b0;
        ra = 4'd15; rb = 4'd0;
        // Same edge as the sweep request: write r9 (still accepted)
        sreq = 1'b1; we = 1'b1; ws = 4'd9; wd = 8'h99;
        tick();
        chk("sweep_start_busy", sbusy, 1);
        chk("sweep_start_ready", wr, 0);
        // Writes to r7 during SWEEP must be dropped
        ws = 4'd7; wd = 8'h3C;
        busy_cnt = 1; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) begin
                chk("read_during_sweep_a", rda, 8'h1F);
                chk("read_during_sweep_b", rdb, 8'h10);
                rb = 4'd9;
            end
            if (i == 1) chk("write_on_sweep_start", rdb, 8'h99);
            if (i == 3) sreq = 1'b0;
            if (i == 12) we = 1'b0;
            busy_cnt += int'(sbusy);
            done_cnt += int'(sdone);
            if (sdone) chk("ready_in_done", wr, 1);
        end
        chk("sweep_busy_cycles", busy_cnt, 16);
        chk("sweep_done_pulses", done_cnt, 1);
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            tick();
            chk($sformatf("post_sweep_a%0d", i), rda, 0);
            chk($sformatf("post_sweep_b%0d", 15 - i), rdb, 0);
        end

        // Reset in the middle of a sweep
        we = 1'b1; ws = 4'd3; wd = 8'h55;
        tick();
        we = 1'b0; ra = 4'd3;
        tick();
        chk("pre_abort_read", rda, 8'h55);
        sreq = 1'b1;
        tick();
        sreq = 1'b0;
        repeat (8) tick();
        chk("mid_sweep_busy", sbusy, 1);
        #2 clear = 1'b0;
        #1;
        chk("abort_rda_async", rda, 0);
        chk("abort_busy_async", sbusy, 0);
        chk("abort_done_async", sdone, 0);
        chk("abort_ready_async", wr, 1);
        tick(); tick();
        clear = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_cnt += int'(sbusy);
            done_cnt += int'(sdone);
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_busy", busy_cnt, 0);
        we = 1'b1; ws = 4'd2; wd = 8'h77;
        tick();
        we = 1'b0; ra = 4'd2; rb = 4'd3;
        tick();
        chk("after_release_r2", rda, 8'h77);
        chk("after_release_r3", rdb, 0);

        // Wide configuration: 32-bit data, 8 registers
        w_we = 1'b1; w_ws = 3'd7; w_wd = 32'hDEADBEEF;
        tick();
        w_we = 1'b0; w_ra = 3'd7; w_rb = 3'd7;
        tick();
        chk("wide_r7_a", w_rda, 32'hDEADBEEF);
        chk("wide_r7_b", w_rdb, 32'hDEADBEEF);
        w_sreq = 1'b1;
        tick();
        w_sreq = 1'b0;
        busy_cnt = int'(w_sbusy); done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_cnt += int'(w_sbusy);
            done_cnt += int'(w_sdone);
        end
        chk("wide_sweep_cycles", busy_cnt, 8);
        chk("wide_sweep_done", done_cnt, 1);
        chk("wide_post_sweep_r7", w_rda, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
